// File: rtl/vend_core_param_if.sv
// ----------------------------------------------------------------------------
// vend_core_param_if
//   Bundle of the request strobes and status outputs that connect the keypad /
//   edge-detect front end to the vending control core.
//
//   Front end -> core : sel_valid, sel_idx, coin_valid, coin_val, cancel
//   Core -> front end : credit, sel_active, cur_idx, dispense_valid,
//                       dispense_idx, change_valid, change_amt, err, sold_out
//
//   master modport : the front end (drives the strobes)
//   slave modport  : the control core
// ----------------------------------------------------------------------------
interface vend_core_param_if #(
  parameter int NUM_PRODUCTS = 5,
  parameter int AMT_W        = 8
);
  logic                    sel_valid;
  logic [3:0]              sel_idx;
  logic                    coin_valid;
  logic [1:0]              coin_val;
  logic                    cancel;

  logic [AMT_W-1:0]        credit;
  logic                    sel_active;
  logic [3:0]              cur_idx;
  logic                    dispense_valid;
  logic [3:0]              dispense_idx;
  logic                    change_valid;
  logic [AMT_W-1:0]        change_amt;
  logic                    err;
  logic [NUM_PRODUCTS-1:0] sold_out;

  modport master (
    output sel_valid, sel_idx, coin_valid, coin_val, cancel,
    input  credit, sel_active, cur_idx, dispense_valid, dispense_idx,
           change_valid, change_amt, err, sold_out
  );

  modport slave (
    input  sel_valid, sel_idx, coin_valid, coin_val, cancel,
    output credit, sel_active, cur_idx, dispense_valid, dispense_idx,
           change_valid, change_amt, err, sold_out
  );
endinterface

// File: rtl/vend_core_param.sv
// ----------------------------------------------------------------------------
// vend_core_param
//   Parametrised vending-machine control core: product selection with stock
//   tracking, coin collection, dispense, change / refund and an inactivity
//   timeout that refunds automatically.
//
//   Ports:
//     clk   rising-edge clock
//     rstn  asynchronous active-low reset
//     bus   vend_core_param_if.slave
//           in : sel_valid, sel_idx[3:0], coin_valid, coin_val[1:0], cancel
//           out: credit, sel_active, cur_idx, dispense_valid, dispense_idx,
//                change_valid, change_amt, err, sold_out[NUM_PRODUCTS-1:0]
//
//   Optional feature macro: VEND_COIN_CHANGE_EN
//     undefined : change/refund is paid as one pulse carrying the full amount
//     defined   : change/refund is paid one coin per cycle, greedy 10/5/1
//
//   All outputs come straight from registers.
// ----------------------------------------------------------------------------
module vend_core_param #(
  parameter int                            NUM_PRODUCTS = 5,
  parameter int                            AMT_W        = 8,
  parameter logic [NUM_PRODUCTS*AMT_W-1:0] PRICES       = {8'd18, 8'd15, 8'd7, 8'd5, 8'd2},
  parameter int                            STOCK_W      = 4,
  parameter int                            STOCK_INIT   = 3,
  parameter int                            TIMEOUT_CYC  = 1000
) (
  input  logic              clk,
  input  logic              rstn,
  vend_core_param_if.slave  bus
);

  localparam int                CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t           state_reg, state_next;
  logic [AMT_W-1:0] credit_reg, credit_next;
  logic [AMT_W-1:0] price_reg, price_next;
  logic [AMT_W-1:0] rem_reg, rem_next;
  logic [3:0]       idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             sel_active_reg, sel_active_next;
  logic             dispense_valid_reg, dispense_valid_next;
  logic [3:0]       dispense_idx_reg, dispense_idx_next;
  logic             change_valid_reg, change_valid_next;
  logic [AMT_W-1:0] change_amt_reg, change_amt_next;
  logic             err_reg, err_next;

  // 16-entry lookup tables so any 4-bit sel_idx can index them safely;
  // entries beyond NUM_PRODUCTS read as "not available".
  logic [AMT_W-1:0] price_tab [16];
  logic [15:0]      avail_vec;

  logic [AMT_W-1:0] coin_amt;
  logic             coin_legal;
  logic [AMT_W-1:0] credit_sum;
  logic             pay_start;
  logic [AMT_W-1:0] pay_total;
  logic [AMT_W-1:0] pay_coin;
  logic             go_idle;

  // Amount paid out in one CHANGE cycle for an outstanding remainder.
  function automatic logic [AMT_W-1:0] coin_for(input logic [AMT_W-1:0] amt);
`ifdef VEND_COIN_CHANGE_EN
    if (amt >= AMT_W'(10))      return AMT_W'(10);
    else if (amt >= AMT_W'(5))  return AMT_W'(5);
    else if (amt != '0)         return AMT_W'(1);
    else                        return '0;
`else
    return amt;
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Per-product stock counters. sold_out is kept as its own register, updated
  // together with the counter, so it is a registered output rather than a
  // decode of the count.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_prod
      if (gi < NUM_PRODUCTS) begin : g_real
        logic [STOCK_W-1:0] stock_reg;
        logic               so_reg;
        logic               take;

        assign take = (state_reg == VEND) && (idx_reg == 4'(gi)) && (stock_reg != '0);

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            stock_reg <= STOCK_W'(STOCK_INIT);
            so_reg    <= (STOCK_INIT == 0);
          end else if (take) begin
            stock_reg <= stock_reg - STOCK_W'(1);
            so_reg    <= (stock_reg == STOCK_W'(1));
          end
        end

        assign price_tab[gi]    = PRICES[gi*AMT_W +: AMT_W];
        assign avail_vec[gi]    = ~so_reg;
        assign bus.sold_out[gi] = so_reg;
      end else begin : g_pad
        assign price_tab[gi] = '0;
        assign avail_vec[gi] = 1'b0;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Coin decode. Illegal code 11 (or no strobe) contributes nothing.
  // --------------------------------------------------------------------------
  always_comb begin
    coin_amt   = '0;
    coin_legal = 1'b0;
    if (bus.coin_valid) begin
      case (bus.coin_val)
        2'b00:   begin coin_amt = AMT_W'(1);  coin_legal = 1'b1; end
        2'b01:   begin coin_amt = AMT_W'(5);  coin_legal = 1'b1; end
        2'b10:   begin coin_amt = AMT_W'(10); coin_legal = 1'b1; end
        default: begin coin_amt = '0;         coin_legal = 1'b0; end
      endcase
    end
  end

  // Credit never exceeds price+9, so this sum cannot wrap.
  assign credit_sum = credit_reg + coin_amt;

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next          = state_reg;
    credit_next         = credit_reg;
    price_next          = price_reg;
    rem_next            = rem_reg;
    idx_next            = idx_reg;
    cnt_next            = cnt_reg;
    dispense_valid_next = 1'b0;
    dispense_idx_next   = dispense_idx_reg;
    change_valid_next   = 1'b0;
    change_amt_next     = change_amt_reg;
    err_next            = 1'b0;
    pay_start           = 1'b0;
    pay_total           = '0;
    pay_coin            = '0;
    go_idle             = 1'b0;

    case (state_reg)
      IDLE: begin
        // Coins are not accepted without a selection; flag them.
        err_next = bus.coin_valid || (bus.sel_valid && !avail_vec[bus.sel_idx]);
        if (bus.sel_valid && avail_vec[bus.sel_idx]) begin
          idx_next    = bus.sel_idx;
          price_next  = price_tab[bus.sel_idx];
          credit_next = '0;
          cnt_next    = '0;
          state_next  = COLLECT;
        end
      end

      COLLECT: begin
        err_next = bus.coin_valid && !coin_legal;
        // A legal coin arriving on the timeout edge shows the customer is
        // present, so it suppresses the automatic refund.
        if (bus.cancel || ((cnt_reg == CNT_LAST) && !coin_legal)) begin
          // Cancel wins over a simultaneous coin; that coin joins the refund.
          if (credit_sum == '0) begin
            go_idle = 1'b1;
          end else begin
            pay_start = 1'b1;
            pay_total = credit_sum;
          end
        end else if (coin_legal) begin
          credit_next = credit_sum;
          cnt_next    = '0;
          if (credit_sum >= price_reg) begin
            state_next          = VEND;
            dispense_valid_next = 1'b1;
            dispense_idx_next   = idx_reg;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      VEND: begin
        if (credit_reg != price_reg) begin
          pay_start = 1'b1;
          pay_total = credit_reg - price_reg;
        end else begin
          go_idle = 1'b1;
        end
      end

      CHANGE: begin
        // Without coin-by-coin payout the remainder is already zero here.
        if (rem_reg != '0) begin
          pay_start = 1'b1;
          pay_total = rem_reg;
        end else begin
          go_idle = 1'b1;
        end
      end

      default: go_idle = 1'b1;
    endcase

    if (pay_start) begin
      pay_coin          = coin_for(pay_total);
      state_next        = CHANGE;
      change_valid_next = 1'b1;
      change_amt_next   = pay_coin;
      rem_next          = pay_total - pay_coin;
    end

    if (go_idle) begin
      state_next  = IDLE;
      credit_next = '0;
      rem_next    = '0;
    end

    sel_active_next = (state_next == COLLECT) || (state_next == VEND);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg          <= IDLE;
      credit_reg         <= '0;
      price_reg          <= '0;
      rem_reg            <= '0;
      idx_reg            <= '0;
      cnt_reg            <= '0;
      sel_active_reg     <= 1'b0;
      dispense_valid_reg <= 1'b0;
      dispense_idx_reg   <= '0;
      change_valid_reg   <= 1'b0;
      change_amt_reg     <= '0;
      err_reg            <= 1'b0;
    end else begin
      state_reg          <= state_next;
      credit_reg         <= credit_next;
      price_reg          <= price_next;
      rem_reg            <= rem_next;
      idx_reg            <= idx_next;
      cnt_reg            <= cnt_next;
      sel_active_reg     <= sel_active_next;
      dispense_valid_reg <= dispense_valid_next;
      dispense_idx_reg   <= dispense_idx_next;
      change_valid_reg   <= change_valid_next;
      change_amt_reg     <= change_amt_next;
      err_reg            <= err_next;
    end
  end

  assign bus.credit         = credit_reg;
  assign bus.sel_active     = sel_active_reg;
  assign bus.cur_idx        = idx_reg;
  assign bus.dispense_valid = dispense_valid_reg;
  assign bus.dispense_idx   = dispense_idx_reg;
  assign bus.change_valid   = change_valid_reg;
  assign bus.change_amt     = change_amt_reg;
  assign bus.err            = err_reg;

endmodule
